// File: rtl/arb_pkg.sv
// Shared types and constants for the asynchronous request arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DROP  = 2'd2
   } arb_state_t;

   localparam int unsigned DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/sync_high.sv
// Two-flop synchronizer for one asynchronous level; clears on reset.
module sync_high (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two register stages give the first stage a full cycle to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter granting one shared resource to asynchronous
// requesters through a 4-phase req/ack handshake, with a watchdog that
// releases a grant the resource never completes.
module async_req_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         async_req,
   output logic [NUM_REQ-1:0]         ack,
   output logic                       grant_valid,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       res_start,
   input  logic                       res_done,
   output logic                       timeout_err
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [IW-1:0] ID_LAST  = IW'(NUM_REQ - 1);

   logic [NUM_REQ-1:0] req_s;
   arb_state_t         state;
   logic [IW-1:0]      ptr;
   logic [CW-1:0]      cnt;
   logic               pick_found;
   logic [IW-1:0]      pick_id;
   logic [NUM_REQ-1:0] pick_onehot;

   // Each request line crosses into the clk domain on its own synchronizer.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_sync
      sync_high u_sync (
         .clk (clk),
         .rst (rst),
         .d   (async_req[g]),
         .q   (req_s[g])
      );
   end

   // First set request searching circularly upward from start; the index
   // wrap is done explicitly so non-power-of-two NUM_REQ works too.
   function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [IW-1:0]      start);
      logic          found;
      logic [IW-1:0] sel;
      int unsigned   idx;
      found = 1'b0;
      sel   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(start) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[IW'(idx)]) begin
            found = 1'b1;
            sel   = IW'(idx);
         end
      end
      return {found, sel};
   endfunction

   // Candidate for the next grant and its one-hot acknowledge pattern.
   always_comb begin
      {pick_found, pick_id} = rr_pick(req_s, ptr);
      pick_onehot           = '0;
      pick_onehot[pick_id]  = 1'b1;
   end

   // Grant sequencing: arbitrate, wait for done or watchdog, then wait for
   // the granted requester to withdraw before returning to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         ack         <= '0;
         grant_id    <= '0;
         res_start   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         res_start   <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state     <= GRANT;
                  ack       <= pick_onehot;
                  grant_id  <= pick_id;
                  res_start <= 1'b1;
                  cnt       <= '0;
               end
            end
            GRANT: begin
               cnt <= cnt + 1'b1;
               // Completion takes priority over a watchdog expiring in the same cycle.
               if (res_done) begin
                  state <= DROP;
               end else if (cnt == CNT_LAST) begin
                  state       <= DROP;
                  timeout_err <= 1'b1;
               end
            end
            DROP: begin
               if (!req_s[grant_id]) begin
                  state <= IDLE;
                  ack   <= '0;
                  ptr   <= (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign grant_valid = |ack;

endmodule

// File: tb/tb_async_req_arbiter.sv
// Self-checking bench for async_req_arbiter (NUM_REQ=4, TIMEOUT=8).
module tb_async_req_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] async_req = '0;
   logic       res_done = 1'b0;
   logic [3:0] ack;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic       res_start;
   logic       timeout_err;

   int n_cmp  = 0;
   int n_fail = 0;
   int mptr   = 0;   // reference round-robin pointer

   always #5 clk = ~clk;

   async_req_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .async_req   (async_req),
      .ack         (ack),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .res_start   (res_start),
      .res_done    (res_done),
      .timeout_err (timeout_err)
   );

   // Reference: first requester at or after p in circular order.
   function automatic int model_pick(logic [3:0] m, int p);
      for (int d = 0; d < N; d++) begin
         int j;
         j = (p + d) % N;
         if (m[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [3:0] onehot(int i);
      logic [3:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(output int lat);
      lat = 0;
      do begin tick(); lat++; end while (ack == '0 && lat < 20);
   endtask

   task automatic acquire(input logic [3:0] m, output int lat);
      async_req = m;
      wait_ack(lat);
   endtask

   task automatic drop_wait(input logic [3:0] r, output int lat);
      async_req = r;
      lat = 0;
      do begin tick(); lat++; end while (ack != '0 && lat < 20);
   endtask

   task automatic finish_done();
      res_done = 1'b1;
      tick();
      res_done = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1; async_req = '0; res_done = 1'b0;
      tick(); tick();
      rst = 1'b0;
      mptr = 0;
      tick();
   endtask

   task automatic test_reset();
      tick(); tick();
      n_cmp++; if ({ack, grant_valid, grant_id, res_start, timeout_err} !== 9'b0) begin
         n_fail++; $display("FAIL reset_outputs: got ack=%b gv=%b id=%0d rs=%b te=%b want all 0", ack, grant_valid, grant_id, res_start, timeout_err);
      end
      rst = 1'b0; mptr = 0;
      tick();
      res_done = 1'b1; tick(); res_done = 1'b0; tick(); tick();
      n_cmp++; if ({ack, grant_valid, res_start, timeout_err} !== 7'b0) begin
         n_fail++; $display("FAIL idle_done_ignored: got ack=%b gv=%b rs=%b te=%b want 0", ack, grant_valid, res_start, timeout_err);
      end
   endtask

   task automatic test_single();
      int lat, e;
      acquire(4'b0010, lat);
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL single_latency: got %0d want 3", lat); end
      n_cmp++; if (ack !== 4'b0010 || grant_id !== 2'd1 || grant_valid !== 1'b1 || res_start !== 1'b1) begin
         n_fail++; $display("FAIL single_grant: got ack=%b id=%0d gv=%b rs=%b want 0010/1/1/1", ack, grant_id, grant_valid, res_start);
      end
      tick();
      n_cmp++; if (res_start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: got %b want 0", res_start); end
      finish_done();
      drop_wait(4'b0000, lat);
      n_cmp++; if (lat !== 3 || grant_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_drop: got lat=%0d gv=%b want 3/0", lat, grant_valid);
      end
      mptr = 2;
      tick();
      e = model_pick(4'b1110, mptr);
      acquire(4'b1110, lat);
      n_cmp++; if (grant_id !== e[1:0] || ack !== onehot(e)) begin
         n_fail++; $display("FAIL ptr_after_single: got id=%0d ack=%b want id=%0d", grant_id, ack, e);
      end
      finish_done();
      drop_wait(4'b0000, lat);
      mptr = (e + 1) % N;
      tick();
   endtask

   task automatic test_wrap();
      int lat, e;
      e = model_pick(4'b1001, mptr);
      acquire(4'b1001, lat);
      n_cmp++; if (grant_id !== e[1:0] || e !== 3 || lat !== 3) begin
         n_fail++; $display("FAIL wrap_first: got id=%0d lat=%0d want id=3 lat=3", grant_id, lat);
      end
      finish_done();
      drop_wait(4'b0001, lat);
      mptr = (e + 1) % N;
      e = model_pick(4'b0001, mptr);
      wait_ack(lat);
      n_cmp++; if (grant_id !== e[1:0] || ack !== onehot(e) || lat !== 1) begin
         n_fail++; $display("FAIL wrap_second: got id=%0d ack=%b lat=%0d want id=%0d lat=1", grant_id, ack, lat, e);
      end
      finish_done();
      drop_wait(4'b0000, lat);
      mptr = (e + 1) % N;
      tick();
   endtask

   task automatic test_fairness();
      int lat, e, dl;
      int order[5] = '{0, 1, 2, 3, 0};
      apply_reset();
      async_req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         e = model_pick(4'b1111, mptr);
         wait_ack(lat);
         n_cmp++; if (grant_id !== e[1:0] || e !== order[g] || ack !== onehot(e) || lat !== (g == 0 ? 3 : 1)) begin
            n_fail++; $display("FAIL fair_grant%0d: got id=%0d ack=%b lat=%0d want id=%0d", g, grant_id, ack, lat, order[g]);
         end
         finish_done();
         drop_wait(4'b1111 & ~onehot(e), dl);
         n_cmp++; if (dl !== 3) begin n_fail++; $display("FAIL fair_drop%0d: got %0d want 3", g, dl); end
         mptr = (e + 1) % N;
         async_req = 4'b1111;
      end
      wait_ack(lat);
      finish_done();
      drop_wait(4'b0000, lat);
      mptr = (int'(grant_id) + 1) % N;
      tick();
   endtask

   task automatic test_watchdog();
      int lat, e, c;
      e = model_pick(4'b0010, mptr);
      acquire(4'b0010, lat);
      c = 0;
      do begin tick(); c++; end while (timeout_err !== 1'b1 && c < 40);
      n_cmp++; if (c !== TO || ack !== onehot(e)) begin
         n_fail++; $display("FAIL watchdog_fire: got cycles=%0d ack=%b want %0d ack=%b", c, ack, TO, onehot(e));
      end
      tick();
      n_cmp++; if (timeout_err !== 1'b0 || ack !== onehot(e)) begin
         n_fail++; $display("FAIL watchdog_pulse: got te=%b ack=%b want 0 and held ack", timeout_err, ack);
      end
      drop_wait(4'b0000, lat);
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL watchdog_drop: got %0d want 3", lat); end
      mptr = (e + 1) % N;
      tick();
   endtask

   task automatic test_collision();
      int lat, e, seen;
      e = model_pick(4'b0100, mptr);
      acquire(4'b0100, lat);
      seen = 0;
      repeat (TO - 1) begin tick(); if (timeout_err) seen++; end
      res_done = 1'b1; tick(); res_done = 1'b0;
      if (timeout_err) seen++;
      tick();
      if (timeout_err) seen++;
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL collision_no_timeout: got %0d pulses want 0", seen); end
      drop_wait(4'b0000, lat);
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL collision_drop: got %0d want 3", lat); end
      mptr = (e + 1) % N;
      tick();
   endtask

   task automatic test_reset_mid_grant();
      int lat, e;
      acquire(4'b0100, lat);
      n_cmp++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL midrst_pre: got %b want 0100", ack); end
      #2; rst = 1'b1; #1;
      n_cmp++; if ({ack, grant_valid, grant_id, res_start, timeout_err} !== 9'b0) begin
         n_fail++; $display("FAIL midrst_async: got ack=%b gv=%b id=%0d rs=%b te=%b want all 0", ack, grant_valid, grant_id, res_start, timeout_err);
      end
      async_req = '0;
      tick(); tick();
      rst = 1'b0; mptr = 0;
      tick(); tick(); tick();
      n_cmp++; if (ack !== 4'b0 || grant_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_idle: got ack=%b gv=%b want 0", ack, grant_valid);
      end
      e = model_pick(4'b1110, mptr);
      acquire(4'b1110, lat);
      n_cmp++; if (grant_id !== e[1:0] || lat !== 3) begin
         n_fail++; $display("FAIL midrst_ptr: got id=%0d lat=%0d want id=%0d lat=3", grant_id, lat, e);
      end
      finish_done();
      drop_wait(4'b0000, lat);
      mptr = (e + 1) % N;
      tick();
   endtask

   task automatic test_random();
      int lat, e, c, dly, bad;
      logic [3:0] m;
      for (int it = 0; it < 24; it++) begin
         m = 4'($urandom_range(1, 15));
         e = model_pick(m, mptr);
         acquire(m, lat);
         n_cmp++; if (grant_id !== e[1:0] || ack !== onehot(e) || lat !== 3 || res_start !== 1'b1) begin
            n_fail++; $display("FAIL rand%0d_grant: req=%b got id=%0d ack=%b lat=%0d rs=%b want id=%0d", it, m, grant_id, ack, lat, res_start, e);
         end
         if ($urandom_range(0, 1) == 1) begin
            dly = $urandom_range(0, TO - 2);
            bad = 0;
            repeat (dly) begin tick(); if (timeout_err) bad++; end
            finish_done();
            if (timeout_err) bad++;
            n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rand%0d_done: got %0d timeout pulses want 0", it, bad); end
         end else begin
            c = 0;
            do begin tick(); c++; end while (timeout_err !== 1'b1 && c < 40);
            n_cmp++; if (c !== TO) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d want %0d", it, c, TO); end
         end
         drop_wait(4'b0000, lat);
         n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rand%0d_drop: got %0d want 3", it, lat); end
         mptr = (e + 1) % N;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_fairness();
      test_watchdog();
      test_collision();
      test_reset_mid_grant();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
